// File: rtl/sigma_mem_arb_if.sv
// rtl/sigma_mem_arb_if.sv - request/response bundle between two masters, the arbiter and the shared slave
interface sigma_mem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              m0_req_i;
   logic              m0_we_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [BE_W-1:0]   m0_be_i;
   logic [DATA_W-1:0] m0_wdata_i;
   logic              m0_ack_o;
   logic              m0_resp_o;
   logic              m0_err_o;
   logic [DATA_W-1:0] m0_rdata_o;

   logic              m1_req_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [BE_W-1:0]   m1_be_i;
   logic [DATA_W-1:0] m1_wdata_i;
   logic              m1_ack_o;
   logic              m1_resp_o;
   logic              m1_err_o;
   logic [DATA_W-1:0] m1_rdata_o;

   logic              s_req_o;
   logic              s_we_o;
   logic [ADDR_W-1:0] s_addr_o;
   logic [BE_W-1:0]   s_be_o;
   logic [DATA_W-1:0] s_wdata_o;
   logic              s_ack_i;
   logic              s_resp_i;
   logic [DATA_W-1:0] s_rdata_i;

   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
      input  s_ack_i, s_resp_i, s_rdata_i,
      output m0_ack_o, m0_resp_o, m0_err_o, m0_rdata_o,
      output m1_ack_o, m1_resp_o, m1_err_o, m1_rdata_o,
      output s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o
   );

   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
      output m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
      output s_ack_i, s_resp_i, s_rdata_i,
      input  m0_ack_o, m0_resp_o, m0_err_o, m0_rdata_o,
      input  m1_ack_o, m1_resp_o, m1_err_o, m1_rdata_o,
      input  s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o
   );
endinterface

// File: rtl/sigma_mem_arb.sv
// rtl/sigma_mem_arb.sv - two-master arbiter onto one memory slave, one outstanding read with timeout
module sigma_mem_arb #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                FIXED_PRIO = 0,
   parameter int                TIMEOUT    = 255,
   parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(32'hDEADBEEF)
) (
   input logic           clk_i,
   input logic           arst_i,
   sigma_mem_arb_if.slave bus
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic {IDLE, WAIT_RESP} state_t;

   state_t      state, state_nx;
   logic        owner, owner_nx;
   logic        last, last_nx;
   logic        hold_vld, hold_vld_nx;
   logic        hold_own, hold_own_nx;
   logic [31:0] cnt, cnt_nx;

   logic              sel, sel_vld, tie_win, timeout_hit;
   logic              s_req, s_we;
   logic [ADDR_W-1:0] s_addr;
   logic [BE_W-1:0]   s_be;
   logic [DATA_W-1:0] s_wdata;
   logic [1:0]        ack, resp, err;
   logic [DATA_W-1:0] rdata0, rdata1;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b1;
         hold_vld <= 1'b0;
         hold_own <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         last     <= last_nx;
         hold_vld <= hold_vld_nx;
         hold_own <= hold_own_nx;
         cnt      <= cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      owner_nx    = owner;
      last_nx     = last;
      hold_vld_nx = hold_vld;
      hold_own_nx = hold_own;
      cnt_nx      = cnt;
      s_req       = 1'b0;
      s_we        = 1'b0;
      s_addr      = '0;
      s_be        = '0;
      s_wdata     = '0;
      ack         = 2'b00;
      resp        = 2'b00;
      err         = 2'b00;
      rdata0      = '0;
      rdata1      = '0;

      // A stalled handshake keeps its master until the slave accepts or the master withdraws.
      tie_win     = (FIXED_PRIO != 0) ? 1'b1 : ~last;
      timeout_hit = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));
      sel_vld     = bus.m0_req_i | bus.m1_req_i;
      if (hold_vld && (hold_own ? bus.m1_req_i : bus.m0_req_i))
         sel = hold_own;
      else if (bus.m0_req_i && bus.m1_req_i)
         sel = tie_win;
      else
         sel = bus.m1_req_i;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (sel_vld) begin
               s_req   = 1'b1;
               s_we    = sel ? bus.m1_we_i    : bus.m0_we_i;
               s_addr  = sel ? bus.m1_addr_i  : bus.m0_addr_i;
               s_be    = sel ? bus.m1_be_i    : bus.m0_be_i;
               s_wdata = sel ? bus.m1_wdata_i : bus.m0_wdata_i;
               ack[sel] = bus.s_ack_i;
               if (bus.s_ack_i) begin
                  last_nx     = sel;
                  hold_vld_nx = 1'b0;
                  if (!s_we) begin
                     owner_nx = sel;
                     state_nx = WAIT_RESP;
                  end
               end else begin
                  hold_vld_nx = 1'b1;
                  hold_own_nx = sel;
               end
            end else begin
               hold_vld_nx = 1'b0;
            end
         end
         WAIT_RESP: begin
            if (bus.s_resp_i || timeout_hit) begin
               resp[owner]  = 1'b1;
               err[owner]   = ~bus.s_resp_i;
               if (owner) rdata1 = bus.s_resp_i ? bus.s_rdata_i : ERR_DATA;
               else       rdata0 = bus.s_resp_i ? bus.s_rdata_i : ERR_DATA;
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (arst_i) begin
         s_req   = 1'b0;
         s_we    = 1'b0;
         s_addr  = '0;
         s_be    = '0;
         s_wdata = '0;
         ack     = 2'b00;
         resp    = 2'b00;
         err     = 2'b00;
         rdata0  = '0;
         rdata1  = '0;
      end
   end

   assign bus.s_req_o    = s_req;
   assign bus.s_we_o     = s_we;
   assign bus.s_addr_o   = s_addr;
   assign bus.s_be_o     = s_be;
   assign bus.s_wdata_o  = s_wdata;
   assign bus.m0_ack_o   = ack[0];
   assign bus.m1_ack_o   = ack[1];
   assign bus.m0_resp_o  = resp[0];
   assign bus.m1_resp_o  = resp[1];
   assign bus.m0_err_o   = err[0];
   assign bus.m1_err_o   = err[1];
   assign bus.m0_rdata_o = rdata0;
   assign bus.m1_rdata_o = rdata1;
endmodule

// File: tb/tb_sigma_mem_arb.sv
// tb/tb_sigma_mem_arb.sv - directed vector bench for sigma_mem_arb (round-robin and fixed-priority builds)
module tb_sigma_mem_arb;
   logic clk = 1'b0;
   logic arst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sigma_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
   sigma_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

   sigma_mem_arb #(.FIXED_PRIO(0), .TIMEOUT(4)) dut_rr (.clk_i(clk), .arst_i(arst), .bus(bus_rr));
   sigma_mem_arb #(.FIXED_PRIO(1))              dut_fp (.clk_i(clk), .arst_i(arst), .bus(bus_fp));

   assign bus_fp.m0_req_i   = bus_rr.m0_req_i;
   assign bus_fp.m0_we_i    = bus_rr.m0_we_i;
   assign bus_fp.m0_addr_i  = bus_rr.m0_addr_i;
   assign bus_fp.m0_be_i    = bus_rr.m0_be_i;
   assign bus_fp.m0_wdata_i = bus_rr.m0_wdata_i;
   assign bus_fp.m1_req_i   = bus_rr.m1_req_i;
   assign bus_fp.m1_we_i    = bus_rr.m1_we_i;
   assign bus_fp.m1_addr_i  = bus_rr.m1_addr_i;
   assign bus_fp.m1_be_i    = bus_rr.m1_be_i;
   assign bus_fp.m1_wdata_i = bus_rr.m1_wdata_i;
   assign bus_fp.s_ack_i    = bus_rr.s_ack_i;
   assign bus_fp.s_resp_i   = bus_rr.s_resp_i;
   assign bus_fp.s_rdata_i  = bus_rr.s_rdata_i;

   typedef struct {
      logic        m0_req, m0_we, m1_req, m1_we, ack, resp;
      logic [31:0] rdata;
      logic        e_sreq;
      logic [31:0] e_addr;
      logic [1:0]  e_ack, e_resp, e_err;
      logic [31:0] e_rd0, e_rd1;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(input logic m0r, m0w, m1r, m1w, a, r, input logic [31:0] rd,
                               input logic sreq, input logic [31:0] addr,
                               input logic [1:0] eack, eresp, eerr, input logic [31:0] rd0, rd1);
      vec_t v;
      v.m0_req = m0r; v.m0_we = m0w; v.m1_req = m1r; v.m1_we = m1w;
      v.ack = a; v.resp = r; v.rdata = rd;
      v.e_sreq = sreq; v.e_addr = addr; v.e_ack = eack; v.e_resp = eresp; v.e_err = eerr;
      v.e_rd0 = rd0; v.e_rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic m0r, m0w, m1r, m1w, a, r, input logic [31:0] rd);
      @(posedge clk);
      #1;
      bus_rr.m0_req_i = m0r; bus_rr.m0_we_i = m0w;
      bus_rr.m1_req_i = m1r; bus_rr.m1_we_i = m1w;
      bus_rr.s_ack_i = a; bus_rr.s_resp_i = r; bus_rr.s_rdata_i = rd;
   endtask

   task automatic do_reset();
      arst = 1'b1;
      bus_rr.m0_req_i = 1'b0; bus_rr.m1_req_i = 1'b0;
      bus_rr.s_ack_i = 1'b0; bus_rr.s_resp_i = 1'b0; bus_rr.s_rdata_i = '0;
      repeat (2) @(posedge clk);
      #1 arst = 1'b0;
   endtask

   initial begin
      bus_rr.m0_addr_i = 32'h100; bus_rr.m0_be_i = 4'hF; bus_rr.m0_wdata_i = 32'hA0A0_0000;
      bus_rr.m1_addr_i = 32'h200; bus_rr.m1_be_i = 4'hF; bus_rr.m1_wdata_i = 32'hB1B1_0000;
      bus_rr.m0_we_i = 1'b0; bus_rr.m1_we_i = 1'b0;
      bus_rr.m0_req_i = 1'b1; bus_rr.m1_req_i = 1'b1;
      bus_rr.s_ack_i = 1'b1; bus_rr.s_resp_i = 1'b1; bus_rr.s_rdata_i = 32'h1111_1111;

      // outputs held at zero during reset even with live inputs
      @(negedge clk);
      chk("rst_sreq", 0, {31'b0, bus_rr.s_req_o}, 0);
      chk("rst_acks", 0, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, 0);
      chk("rst_resp", 0, {30'b0, bus_rr.m1_resp_o, bus_rr.m0_resp_o}, 0);
      chk("rst_rd0", 0, bus_rr.m0_rdata_o, 0);

      tbl[0]  = mk(0,0,0,0,0,0,0,            0,32'h000,2'b00,2'b00,2'b00,0,0);
      tbl[1]  = mk(1,1,1,1,1,0,0,            1,32'h100,2'b01,2'b00,2'b00,0,0);
      tbl[2]  = mk(1,1,1,1,1,0,0,            1,32'h200,2'b10,2'b00,2'b00,0,0);
      tbl[3]  = mk(1,1,1,1,1,0,0,            1,32'h100,2'b01,2'b00,2'b00,0,0);
      tbl[4]  = mk(1,1,1,1,1,0,0,            1,32'h200,2'b10,2'b00,2'b00,0,0);
      tbl[5]  = mk(1,1,0,0,1,0,0,            1,32'h100,2'b01,2'b00,2'b00,0,0);
      tbl[6]  = mk(1,1,0,0,0,0,0,            1,32'h100,2'b00,2'b00,2'b00,0,0);
      tbl[7]  = mk(1,1,1,1,0,0,0,            1,32'h100,2'b00,2'b00,2'b00,0,0);
      tbl[8]  = mk(1,1,1,1,0,0,0,            1,32'h100,2'b00,2'b00,2'b00,0,0);
      tbl[9]  = mk(1,1,1,1,0,0,0,            1,32'h100,2'b00,2'b00,2'b00,0,0);
      tbl[10] = mk(1,1,1,1,0,0,0,            1,32'h100,2'b00,2'b00,2'b00,0,0);
      tbl[11] = mk(1,1,1,1,1,0,0,            1,32'h100,2'b01,2'b00,2'b00,0,0);
      tbl[12] = mk(1,1,1,1,1,0,0,            1,32'h200,2'b10,2'b00,2'b00,0,0);
      tbl[13] = mk(1,0,1,1,1,0,0,            1,32'h100,2'b01,2'b00,2'b00,0,0);
      tbl[14] = mk(0,0,1,1,1,0,0,            0,32'h000,2'b00,2'b00,2'b00,0,0);
      tbl[15] = mk(0,0,1,1,1,0,0,            0,32'h000,2'b00,2'b00,2'b00,0,0);
      tbl[16] = mk(0,0,1,1,1,1,32'h12345678, 0,32'h000,2'b00,2'b01,2'b00,32'h12345678,0);
      tbl[17] = mk(0,0,1,1,1,0,0,            1,32'h200,2'b10,2'b00,2'b00,0,0);
      tbl[18] = mk(0,0,0,0,0,1,32'h55,       0,32'h000,2'b00,2'b00,2'b00,0,0);

      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].m0_req, tbl[i].m0_we, tbl[i].m1_req, tbl[i].m1_we, tbl[i].ack, tbl[i].resp, tbl[i].rdata);
         @(negedge clk);
         chk("v_sreq", i, {31'b0, bus_rr.s_req_o}, {31'b0, tbl[i].e_sreq});
         chk("v_addr", i, bus_rr.s_addr_o, tbl[i].e_addr);
         chk("v_ack", i, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, {30'b0, tbl[i].e_ack});
         chk("v_resp", i, {30'b0, bus_rr.m1_resp_o, bus_rr.m0_resp_o}, {30'b0, tbl[i].e_resp});
         chk("v_err", i, {30'b0, bus_rr.m1_err_o, bus_rr.m0_err_o}, {30'b0, tbl[i].e_err});
         chk("v_rd0", i, bus_rr.m0_rdata_o, tbl[i].e_rd0);
         chk("v_rd1", i, bus_rr.m1_rdata_o, tbl[i].e_rd1);
      end

      // timeout on an m1 read, then a late response that must be dropped
      do_reset();
      drive(0,0,1,0,1,0,0);
      @(negedge clk) chk("to_ack", 0, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, 2);
      for (int i = 1; i <= 3; i++) begin
         drive(0,0,0,0,0,0,0);
         @(negedge clk) chk("to_wait", i, {30'b0, bus_rr.m1_resp_o, bus_rr.m1_err_o}, 0);
      end
      drive(0,0,0,0,0,0,0);
      @(negedge clk);
      chk("to_resp", 4, {31'b0, bus_rr.m1_resp_o}, 1);
      chk("to_err", 4, {31'b0, bus_rr.m1_err_o}, 1);
      chk("to_rd1", 4, bus_rr.m1_rdata_o, 32'hDEADBEEF);
      chk("to_rd0", 4, bus_rr.m0_rdata_o, 0);
      drive(0,0,0,0,0,1,32'hAAAA_5555);
      @(negedge clk) chk("late_drop", 5, {30'b0, bus_rr.m1_resp_o, bus_rr.m0_resp_o}, 0);

      // response arriving on the timeout cycle wins over the error
      drive(0,0,1,0,1,0,0);
      @(negedge clk) chk("tb_ack", 0, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, 2);
      for (int i = 1; i <= 3; i++) drive(0,0,0,0,0,0,0);
      drive(0,0,0,0,0,1,32'hCAFE_F00D);
      @(negedge clk);
      chk("tb_resp", 4, {31'b0, bus_rr.m1_resp_o}, 1);
      chk("tb_err", 4, {31'b0, bus_rr.m1_err_o}, 0);
      chk("tb_rd1", 4, bus_rr.m1_rdata_o, 32'hCAFE_F00D);

      // reset pulsed while a read is outstanding
      do_reset();
      drive(1,0,0,0,1,0,0);
      @(negedge clk) chk("ar_ack", 0, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, 1);
      drive(1,1,1,1,1,1,32'h7777_7777);
      arst = 1'b1;
      @(negedge clk);
      chk("ar_sreq", 1, {31'b0, bus_rr.s_req_o}, 0);
      chk("ar_acks", 1, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, 0);
      chk("ar_resp", 1, {30'b0, bus_rr.m1_resp_o, bus_rr.m0_resp_o}, 0);
      chk("ar_rd0", 1, bus_rr.m0_rdata_o, 0);
      drive(0,0,0,0,0,1,32'h7777_7777);
      arst = 1'b0;
      @(negedge clk) chk("ar_drop", 2, {30'b0, bus_rr.m1_resp_o, bus_rr.m0_resp_o}, 0);
      drive(1,1,1,1,1,0,0);
      @(negedge clk) chk("ar_tie", 3, {30'b0, bus_rr.m1_ack_o, bus_rr.m0_ack_o}, 1);

      // fixed-priority build: m1 always wins, m0 only once m1 drops
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1,1,1,1,1,0,0);
         @(negedge clk) chk("fp_ack", i, {30'b0, bus_fp.m1_ack_o, bus_fp.m0_ack_o}, 2);
      end
      drive(1,1,0,0,1,0,0);
      @(negedge clk) chk("fp_m0", 3, {30'b0, bus_fp.m1_ack_o, bus_fp.m0_ack_o}, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sigma_mem_arb.md
SIGMA_MEM_ARB -- requirements
Module: sigma_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = master 1 (debug) always wins.
REQ-004 Parameter TIMEOUT, default 255, cycles to wait for a read response before an error response is returned; 0 disables the timeout.
REQ-005 Parameter ERR_DATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-006 clk_i  in  1  clock; all logic is on the rising edge.
REQ-007 arst_i  in  1  asynchronous reset, active-high.
REQ-008 mN_req_i / mN_we_i / mN_addr_i / mN_be_i / mN_wdata_i  in  1/1/ADDR_W/DATA_W/8/DATA_W  request from master N (N = 0 CPU, N = 1 debug/UART loader).
REQ-009 mN_ack_o  out  1  request accepted this cycle.
REQ-010 mN_resp_o  out  1  read data valid; mN_rdata_o  out  DATA_W  read data.
REQ-011 mN_err_o  out  1  pulses together with mN_resp_o when the response is a timeout error.
REQ-012 s_req_o / s_we_o / s_addr_o / s_be_o / s_wdata_o  out  request to the shared memory/crossbar slave.
REQ-013 s_ack_i  in  1  slave accepted request; s_resp_i  in  1  read data valid; s_rdata_i  in  DATA_W.

Function
REQ-014 The FSM SHALL have two states: IDLE and WAIT_RESP.
REQ-015 In IDLE the arbiter SHALL select one requesting master combinationally and drive the s_* request outputs from that master's inputs in the same cycle; with no requester, s_req_o = 0.
REQ-016 Round-robin: on a tie the master not granted last wins; last-grant pointer resets to 1, so master 0 wins the first tie.
REQ-017 FIXED_PRIO = 1: master 1 SHALL win every tie.
REQ-018 mN_ack_o SHALL equal s_ack_i gated by the grant of master N; the non-selected master's ack SHALL be 0.
REQ-019 The selection SHALL stay stable while s_req_o = 1 and s_ack_i = 0 (no grant switching mid-handshake), even if the other master raises req.
REQ-020 Accepted write (s_we_o = 1, s_ack_i = 1): the transaction is complete; the FSM stays in IDLE, the pointer updates, a new grant is allowed next cycle.
REQ-021 Accepted read: the owner is latched, the pointer updates, and the FSM enters WAIT_RESP; s_req_o = 0 and both acks = 0 while in WAIT_RESP.
REQ-022 In WAIT_RESP, s_resp_i SHALL be forwarded combinationally to the owner only (mN_resp_o, mN_rdata_o), and the FSM returns to IDLE in the next cycle.
REQ-023 In WAIT_RESP, a counter counts cycles; if it reaches TIMEOUT without s_resp_i, the owner receives a one-cycle resp with err = 1 and rdata = ERR_DATA, and the FSM returns to IDLE.
REQ-024 An s_resp_i arriving in IDLE (late response after a timeout) SHALL be dropped; no mN_resp_o is asserted.
REQ-025 An s_resp_i in the same cycle the counter reaches TIMEOUT SHALL take precedence: normal data, err = 0.
REQ-026 Non-owner mN_rdata_o SHALL be 0; mN_err_o SHALL be 0 except under REQ-023.
REQ-027 At most one read is outstanding; throughput is one write per cycle or one read per two cycles plus slave latency.

Reset
REQ-028 While arst_i = 1: FSM = IDLE, owner = 0, last-grant = 1, timeout counter = 0, and all registered state is cleared asynchronously.
REQ-029 During reset, all outputs SHALL be 0 (s_req_o, acks, resps, errs, rdata).
REQ-030 Reset asserted in WAIT_RESP SHALL abandon the read; a subsequent slave response SHALL be dropped per REQ-024.

Verification
REQ-031 Both masters write continuously, s_ack_i = 1, round-robin: grants alternate m0, m1, m0, m1; no cycle with both acks high.
REQ-032 FIXED_PRIO = 1, both masters request continuously: m1 acked every cycle, m0 never acked until m1 drops req.
REQ-033 m0 read addr 0x100, slave acks then resp after 3 cycles with 0x12345678: m0_resp_o pulses once with 0x12345678; m1 request held 4 cycles, then acked.
REQ-034 TIMEOUT = 4, m1 read, no s_resp_i: m1_resp_o = m1_err_o = 1 with rdata 0xDEADBEEF in the 4th WAIT_RESP cycle; a later s_resp_i is ignored.
REQ-035 s_ack_i held low 5 cycles with m0 granted while m1 raises req: s_addr_o stays m0's address throughout.
REQ-036 arst_i pulsed mid-WAIT_RESP: outputs 0 immediately; after release m0 wins the first tie.
